regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the core's decode stage. It generalises the two-read/one-write file with these additions:
- configurable data width, depth and read-port count;
- a second write port for late (load) writeback;
- a per-register pending-load scoreboard, so decode can detect load-use hazards;
- same-cycle write-to-read bypass on every read port.

Reads are combinational for decode; writes and scoreboard updates are registered.

---
 rtl/regfile_mp.sv | 92 +++++++++
 tb/tb_regfile_mp.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file for decode: NRD combinational read ports
// with same-cycle bypass from the execute and load writeback ports, plus a
// per-register pending-load scoreboard for load-use hazard detection.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic                ex_wen_i,
    input  logic [AW-1:0]       ex_waddr_i,
    input  logic [XLEN-1:0]     ex_wdata_i,
    input  logic                ld_wen_i,
    input  logic [AW-1:0]       ld_waddr_i,
    input  logic [XLEN-1:0]     ld_wdata_i,
    input  logic                sb_set_i,
    input  logic [AW-1:0]       sb_addr_i,
    output logic                busy_any_o
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NREGS-1:0] sb_q;
    logic [NREGS-1:0] sb_d;

    logic ex_zero, ld_zero, sb_zero;
    assign ex_zero = (ZERO_REG != 0) && (ex_waddr_i == '0);
    assign ld_zero = (ZERO_REG != 0) && (ld_waddr_i == '0);
    assign sb_zero = (ZERO_REG != 0) && (sb_addr_i == '0);

    // Next-state array: ld written first so a same-address ex write overrides it.
    always_comb begin
        regs_d = regs_q;
        if (ld_wen_i && !ld_zero) regs_d[ld_waddr_i] = ld_wdata_i;
        if (ex_wen_i && !ex_zero) regs_d[ex_waddr_i] = ex_wdata_i;
    end

    // Next-state scoreboard: a new load issue beats a retiring load on the same register.
    always_comb begin
        sb_d = sb_q;
        if (ld_wen_i) sb_d[ld_waddr_i] = 1'b0;
        if (sb_set_i && !sb_zero) sb_d[sb_addr_i] = 1'b1;
    end

    // Register array and scoreboard state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            sb_q <= '0;
        end else begin
            regs_q <= regs_d;
            sb_q   <= sb_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;
        logic            is_zero;

        assign addr    = rd_addr_i[k*AW +: AW];
        assign is_zero = (ZERO_REG != 0) && (addr == '0);

        // Read mux; later assignments take priority (rst > zero > ex > ld > array).
        always_comb begin
            data = regs_q[addr];
            if (ld_wen_i && (ld_waddr_i == addr)) data = ld_wdata_i;
            if (ex_wen_i && (ex_waddr_i == addr)) data = ex_wdata_i;
            if (is_zero) data = '0;
            if (rst) data = '0;
        end

        // Busy masks a load retiring this cycle so it agrees with the bypassed data.
        always_comb begin
            busy = sb_q[addr] & ~(ld_wen_i && (ld_waddr_i == addr));
            if (is_zero || rst) busy = 1'b0;
        end

        assign rd_data_o[k*XLEN +: XLEN] = data;
        assign rd_busy_o[k]              = busy;
    end

    assign busy_any_o = !rst && (|sb_q);

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with default parameters (32x32, 2 read ports).
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr_i;
    logic [NRD*XLEN-1:0] rd_data_o;
    logic [NRD-1:0]      rd_busy_o;
    logic                ex_wen_i;
    logic [AW-1:0]       ex_waddr_i;
    logic [XLEN-1:0]     ex_wdata_i;
    logic                ld_wen_i;
    logic [AW-1:0]       ld_waddr_i;
    logic [XLEN-1:0]     ld_wdata_i;
    logic                sb_set_i;
    logic [AW-1:0]       sb_addr_i;
    logic                busy_any_o;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_mp dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .rd_busy_o  (rd_busy_o),
        .ex_wen_i   (ex_wen_i),
        .ex_waddr_i (ex_waddr_i),
        .ex_wdata_i (ex_wdata_i),
        .ld_wen_i   (ld_wen_i),
        .ld_waddr_i (ld_waddr_i),
        .ld_wdata_i (ld_wdata_i),
        .sb_set_i   (sb_set_i),
        .sb_addr_i  (sb_addr_i),
        .busy_any_o (busy_any_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ex_wen_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0;
        ld_wen_i = 1'b0; ld_waddr_i = '0; ld_wdata_i = '0;
        sb_set_i = 1'b0; sb_addr_i  = '0;
    endtask

    // Inputs change at negedge; checks happen #1 later, well before the next posedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr_i = {a1, a0};
    endtask

    initial begin
        rst = 1'b1;
        idle();
        set_rd(5'd5, 5'd3);
        @(negedge clk);
        #1;
        check("reset_rd0",      rd_data_o[31:0], 32'h0);
        check("reset_busy",     {30'b0, rd_busy_o}, 32'h0);
        check("reset_busy_any", {31'b0, busy_any_o}, 32'h0);
        rst = 1'b0;

        // Execute-port bypass, then array read-back.
        @(negedge clk);
        ex_wen_i = 1'b1; ex_waddr_i = 5'd7; ex_wdata_i = 32'hDEADBEEF;
        set_rd(5'd7, 5'd0);
        #1 check("ex_bypass", rd_data_o[31:0], 32'hDEADBEEF);
        step(); idle();
        #1 check("ex_array", rd_data_o[31:0], 32'hDEADBEEF);

        // ex/ld collision on the same address: ex wins.
        @(negedge clk);
        ex_wen_i = 1'b1; ex_waddr_i = 5'd3; ex_wdata_i = 32'hAAAA0000;
        ld_wen_i = 1'b1; ld_waddr_i = 5'd3; ld_wdata_i = 32'h5555FFFF;
        set_rd(5'd7, 5'd3);
        #1 check("wcol_bypass", rd_data_o[63:32], 32'hAAAA0000);
        step(); idle();
        #1 check("wcol_array", rd_data_o[63:32], 32'hAAAA0000);

        // Load-port bypass alone.
        ld_wen_i = 1'b1; ld_waddr_i = 5'd10; ld_wdata_i = 32'h00000077;
        set_rd(5'd0, 5'd10);
        #1 check("ld_bypass", rd_data_o[63:32], 32'h00000077);
        step(); idle();
        #1 check("ld_array", rd_data_o[63:32], 32'h00000077);

        // Zero register: write and scoreboard set both dropped.
        ex_wen_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'hFFFFFFFF;
        sb_set_i = 1'b1; sb_addr_i = 5'd0;
        set_rd(5'd0, 5'd10);
        #1 check("zero_bypass", rd_data_o[31:0], 32'h0);
        step(); idle();
        #1;
        check("zero_array",    rd_data_o[31:0], 32'h0);
        check("zero_busy",     {31'b0, rd_busy_o[0]}, 32'h0);
        check("zero_busy_any", {31'b0, busy_any_o}, 32'h0);

        // Scoreboard set at N, retire at M.
        sb_set_i = 1'b1; sb_addr_i = 5'd9;
        set_rd(5'd9, 5'd0);
        #1 check("sb_busy_N", {31'b0, rd_busy_o[0]}, 32'h0);
        step(); idle();
        #1;
        check("sb_busy_N1",     {31'b0, rd_busy_o[0]}, 32'h1);
        check("sb_busy_any_N1", {31'b0, busy_any_o}, 32'h1);
        ld_wen_i = 1'b1; ld_waddr_i = 5'd9; ld_wdata_i = 32'h00000042;
        #1;
        check("sb_busy_M",     {31'b0, rd_busy_o[0]}, 32'h0);
        check("sb_data_M",     rd_data_o[31:0], 32'h00000042);
        check("sb_busy_any_M", {31'b0, busy_any_o}, 32'h1);
        step(); idle();
        #1;
        check("sb_busy_M1",     {31'b0, rd_busy_o[0]}, 32'h0);
        check("sb_busy_any_M1", {31'b0, busy_any_o}, 32'h0);
        check("sb_data_M1",     rd_data_o[31:0], 32'h00000042);

        // Set/clear collision on register 4: set wins.
        sb_set_i = 1'b1; sb_addr_i = 5'd4;
        step(); idle();
        ld_wen_i = 1'b1; ld_waddr_i = 5'd4; ld_wdata_i = 32'h00000099;
        sb_set_i = 1'b1; sb_addr_i = 5'd4;
        set_rd(5'd0, 5'd4);
        #1 check("sc_busy_same", {31'b0, rd_busy_o[1]}, 32'h0);
        step(); idle();
        #1;
        check("sc_busy_next", {31'b0, rd_busy_o[1]}, 32'h1);
        check("sc_busy_any",  {31'b0, busy_any_o}, 32'h1);
        check("sc_data",      rd_data_o[63:32], 32'h00000099);

        // Clear reg 4's pending bit so the reset test below is about reg 5 only.
        ld_wen_i = 1'b1; ld_waddr_i = 5'd4; ld_wdata_i = 32'h00000099;
        step(); idle();

        // Reset pulse between edges clears array and scoreboard.
        ex_wen_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'h00001234;
        sb_set_i = 1'b1; sb_addr_i = 5'd5;
        step(); idle();
        set_rd(5'd5, 5'd6);
        #1;
        check("pre_rst_data", rd_data_o[31:0], 32'h00001234);
        check("pre_rst_busy", {31'b0, rd_busy_o[0]}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_data",     rd_data_o[31:0], 32'h0);
        check("rst_busy",     {31'b0, rd_busy_o[0]}, 32'h0);
        check("rst_busy_any", {31'b0, busy_any_o}, 32'h0);
        // Writes across an edge while reset is held are ignored.
        ex_wen_i = 1'b1; ex_waddr_i = 5'd6; ex_wdata_i = 32'h00000066;
        sb_set_i = 1'b1; sb_addr_i = 5'd6;
        step(); idle();
        rst = 1'b0;
        #1;
        check("post_rst_r5",   rd_data_o[31:0], 32'h0);
        check("post_rst_r6",   rd_data_o[63:32], 32'h0);
        check("post_rst_busy", {30'b0, rd_busy_o}, 32'h0);
        check("post_rst_any",  {31'b0, busy_any_o}, 32'h0);

        // First edge after reset release performs writes.
        ex_wen_i = 1'b1; ex_waddr_i = 5'd6; ex_wdata_i = 32'h00000123;
        step(); idle();
        #1 check("post_rst_write", rd_data_o[63:32], 32'h00000123);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
